// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_mem_pkg : shared state encoding and timeout default           |
// | Revision    : 1.0                                                 |
// +------------------------------------------------------------------+
package cpu_mem_pkg;

  localparam int c_timeout_default = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/addr_segment_check.sv
`default_nettype none
// +------------------------------------------------------------------+
// | addr_segment_check : main-memory vs stack-region segment decode   |
// | Revision           : 1.0                                          |
// +------------------------------------------------------------------+
module addr_segment_check (
  input  logic [15:0] addr,
  input  logic [15:0] sp,
  output logic        seg
);

  logic [16:0] w_diff;

  // Borrow out of sp - addr flags addr > sp (unsigned).
  assign w_diff = {1'b0, sp} - {1'b0, addr};
  assign seg    = sp[11] | sp[10] | w_diff[16];

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_port_arbiter : fetch/data round-robin arbiter onto one memory |
// |                    port with wait timeout                         |
// | Revision         : 1.0                                            |
// +------------------------------------------------------------------+
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int TIMEOUT = c_timeout_default
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] rdata,
  output logic        err,
  input  logic [15:0] SP,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_seg,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata
);

  localparam int c_wait_w = $clog2(TIMEOUT + 1);
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_last_d;
  logic                r_gnt_d;
  logic                r_we;
  logic                r_seg;
  logic                r_err;
  logic [15:0]         r_addr;
  logic [15:0]         r_wdata;
  logic [15:0]         r_rdata;
  logic [c_wait_w-1:0] r_wait;

  logic                w_any;
  logic                w_sel_d;
  logic                w_seg;
  logic                w_timeout;
  logic [15:0]         w_sel_addr;

  assign w_any      = f_req | d_req;
  // On a tie, data wins unless data took the previous grant.
  assign w_sel_d    = d_req & (~f_req | ~r_last_d);
  assign w_sel_addr = w_sel_d ? d_addr : f_addr;
  assign w_timeout  = (r_wait == c_wait_last);

  addr_segment_check u_seg (
    .addr (w_sel_addr),
    .sp   (SP),
    .seg  (w_seg)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_any) w_next = ST_ACCESS;
      ST_ACCESS: if (mem_ready || w_timeout) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_last_d <= 1'b0;
      r_gnt_d  <= 1'b0;
      r_we     <= 1'b0;
      r_seg    <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= 16'h0000;
      r_wdata  <= 16'h0000;
      r_rdata  <= 16'h0000;
      r_wait   <= '0;
    end else begin
      if (r_state == ST_IDLE && w_any) begin
        r_gnt_d  <= w_sel_d;
        r_last_d <= w_sel_d;
        r_we     <= w_sel_d & d_we;
        r_addr   <= w_sel_addr;
        r_wdata  <= d_wdata;
        r_seg    <= w_seg;
        r_err    <= 1'b0;
        r_wait   <= '0;
      end else if (r_state == ST_ACCESS) begin
        if (mem_ready) begin
          r_rdata <= mem_rdata;
          r_err   <= 1'b0;
        end else begin
          r_wait <= r_wait + c_wait_w'(1);
          if (w_timeout) begin
            r_rdata <= 16'h0000;
            r_err   <= 1'b1;
          end
        end
      end
    end
  end

  assign mem_req   = (r_state == ST_ACCESS);
  assign mem_we    = mem_req & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_seg   = r_seg;
  assign f_done    = (r_state == ST_DONE) & ~r_gnt_d;
  assign d_done    = (r_state == ST_DONE) &  r_gnt_d;
  assign err       = (r_state == ST_DONE) &  r_err;
  assign rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed + randomized bench with a          |
// |                       transaction-level reference model           |
// | Revision            : 1.0                                         |
// +------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int TO = 15;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        f_req, d_req, d_we, mem_ready;
  logic [15:0] f_addr, d_addr, d_wdata, SP, mem_rdata;
  logic        f_done, d_done, err, mem_req, mem_we, mem_seg;
  logic [15:0] rdata, mem_addr, mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;
  bit m_last_d = 1'b0;
  bit got_d, got_seg;

  mem_port_arbiter dut (
    .CLK(CLK), .Reset(Reset),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .rdata(rdata), .err(err), .SP(SP),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_seg(mem_seg), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Main memory if SP lies at or above 1 KiB within its 4 KiB window, or addr above SP.
  function automatic bit model_seg(input int sp, input int addr);
    return (((sp / 1024) % 4) != 0) || (addr > sp);
  endfunction

  function automatic logic [15:0] rand_addr(input logic [15:0] sp);
    case ($urandom_range(0, 2))
      0:       return 16'($urandom);
      1:       return sp + 16'($urandom_range(0, 4)) - 16'd2;
      default: return 16'($urandom_range(0, 16'h0FFF));
    endcase
  endfunction

  // Entered #1 after the edge that starts an IDLE cycle with requests already driven.
  task automatic run_access(input int lat, output bit o_got_d, output bit o_seg);
    bit          wd, ewe, eseg;
    logic [15:0] ea, ewd, erd;
    wd   = (d_req && f_req) ? !m_last_d : d_req;
    ea   = wd ? d_addr : f_addr;
    ewe  = wd && d_we;
    ewd  = d_wdata;
    eseg = model_seg(int'(SP), int'(ea));
    erd  = 16'h0000;
    o_seg = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge CLK);
    check("idle_mem_req", {63'd0, mem_req}, 64'd0);
    check("idle_done", {62'd0, f_done, d_done}, 64'd0);
    for (int k = 0; k < TO; k++) begin
      @(posedge CLK); #1;
      mem_ready = (k == lat);
      mem_rdata = 16'($urandom);
      SP        = 16'($urandom);
      if (k == lat) erd = mem_rdata;
      @(negedge CLK);
      if (k == 0) o_seg = mem_seg;
      check("acc_mem_req", {63'd0, mem_req}, 64'd1);
      check("acc_addr", {48'd0, mem_addr}, {48'd0, ea});
      check("acc_we", {63'd0, mem_we}, {63'd0, ewe});
      check("acc_seg", {63'd0, mem_seg}, {63'd0, eseg});
      if (ewe) check("acc_wdata", {48'd0, mem_wdata}, {48'd0, ewd});
      check("acc_done", {62'd0, f_done, d_done}, 64'd0);
      if (k == lat) break;
    end
    @(posedge CLK); #1;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = 16'($urandom);
    @(negedge CLK);
    check("done_f", {63'd0, f_done}, {63'd0, !wd});
    check("done_d", {63'd0, d_done}, {63'd0, wd});
    check("done_err", {63'd0, err}, {63'd0, (lat >= TO)});
    check("done_rdata", {48'd0, rdata}, {48'd0, erd});
    check("done_mem_req", {63'd0, mem_req}, 64'd0);
    o_got_d  = d_done;
    m_last_d = wd;
    @(posedge CLK); #1;
    mem_ready = 1'b0;
    if (wd) d_req = 1'b0; else f_req = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    f_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    f_addr = 0; d_addr = 0; d_wdata = 0; SP = 0; mem_rdata = 0;
    repeat (2) @(negedge CLK);
    check("rst_outputs", {10'd0, f_done, d_done, err, mem_req, mem_we, mem_seg, rdata, mem_addr, mem_wdata}, 64'd0);
    @(posedge CLK); #1;
    Reset = 1'b0;
    @(negedge CLK);
    check("post_rst_outputs", {10'd0, f_done, d_done, err, mem_req, mem_we, mem_seg, rdata, mem_addr, mem_wdata}, 64'd0);
    @(posedge CLK); #1;

    // Fetch-only read, one-cycle memory latency.
    f_req = 1; f_addr = 16'h0100; SP = 16'h03FF;
    run_access(0, got_d, got_seg);
    check("fetch_seg", {63'd0, got_seg}, 64'd0);
    check("fetch_grant", {63'd0, got_d}, 64'd0);

    // Both held: D,F,D,F.
    f_req = 1; f_addr = 16'h0010; d_req = 1; d_addr = 16'h0020; d_we = 0; SP = 16'h0100;
    for (int i = 0; i < 4; i++) begin
      run_access(i, got_d, got_seg);
      check("tie_order", {63'd0, got_d}, {63'd0, (i % 2 == 0)});
      if (i % 2 == 0) d_req = 1; else f_req = 1;
    end
    f_req = 0; d_req = 0;
    @(posedge CLK); #1;
    m_last_d = 1'b0;

    // Segment boundaries.
    SP = 16'h0200; d_req = 1; d_addr = 16'h0200;
    run_access(1, got_d, got_seg);
    check("seg_eq", {63'd0, got_seg}, 64'd0);
    SP = 16'h0200; d_req = 1; d_addr = 16'h0201;
    run_access(1, got_d, got_seg);
    check("seg_above", {63'd0, got_seg}, 64'd1);
    SP = 16'h0400; d_req = 1; d_addr = 16'h0000;
    run_access(1, got_d, got_seg);
    check("seg_sp10", {63'd0, got_seg}, 64'd1);

    // Timeout: memory never ready.
    SP = 16'h0100; d_req = 1; d_addr = 16'h0050;
    run_access(1000, got_d, got_seg);
    check("timeout_grant", {63'd0, got_d}, 64'd1);

    // Write into main memory.
    SP = 16'h0FFF; d_req = 1; d_we = 1; d_addr = 16'h1000; d_wdata = 16'h1234;
    run_access(2, got_d, got_seg);
    check("write_seg", {63'd0, got_seg}, 64'd1);
    d_we = 0;

    // Reset mid-access aborts with no done; afterwards data wins the tie.
    f_req = 1; f_addr = 16'h0300; d_req = 1; d_addr = 16'h0400; SP = 16'h0000;
    @(negedge CLK);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("pre_rst_mem_req", {63'd0, mem_req}, 64'd1);
    #2 Reset = 1'b1;
    #1 check("async_mem_req", {63'd0, mem_req}, 64'd0);
    check("async_done", {62'd0, f_done, d_done}, 64'd0);
    repeat (2) begin
      @(negedge CLK);
      check("rst_hold_done", {61'd0, f_done, d_done, mem_req}, 64'd0);
    end
    @(posedge CLK); #1;
    Reset = 1'b0;
    m_last_d = 1'b0;
    run_access(1, got_d, got_seg);
    check("post_rst_tie", {63'd0, got_d}, 64'd1);
    run_access(0, got_d, got_seg);
    check("post_rst_tie2", {63'd0, got_d}, 64'd0);

    // Randomized traffic; a pending loser keeps its payload.
    for (int it = 0; it < 40; it++) begin
      SP = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 16'h03FF));
      if (!f_req) begin
        f_req  = 1'($urandom_range(0, 1));
        f_addr = rand_addr(SP);
      end
      if (!d_req) begin
        d_req   = 1'($urandom_range(0, 1));
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = rand_addr(SP);
        d_wdata = 16'($urandom);
        if (!f_req) d_req = 1'b1;
      end
      run_access(int'($urandom_range(0, TO + 2)), got_d, got_seg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
